// File: rtl/deca_qsys_sysid_checker.sv
// Avalon-MM master that reads the Qsys sysid slave (ID at word 0, timestamp at word 1)
// and compares both words against build-time constants for a CPU-less board self-test.
module deca_qsys_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1429701634,
    parameter int          CHECK_TIMESTAMP    = 1,
    parameter int          TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  err_code,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid
);

    typedef enum logic [2:0] {
        IDLE,
        ID_CMD,
        ID_WAIT,
        TS_CMD,
        TS_WAIT,
        FINISH
    } state_t;

    localparam logic [1:0]  ERR_OK      = 2'd0;
    localparam logic [1:0]  ERR_ID      = 2'd1;
    localparam logic [1:0]  ERR_TS      = 2'd2;
    localparam logic [1:0]  ERR_TIMEOUT = 2'd3;
    localparam logic [15:0] TIMER_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] wait_timer;
    logic        timed_out;

    // The timer spans a whole command+wait phase; reaching the last allowed
    // cycle without readdatavalid ends the check.
    assign timed_out = (wait_timer >= TIMER_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            wait_timer      <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_code        <= ERR_OK;
            id_value        <= '0;
            timestamp_value <= '0;
            avm_address     <= 1'b0;
            avm_read        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start landing on the done pulse is dropped deliberately.
                    if (start && !done) begin
                        state           <= ID_CMD;
                        busy            <= 1'b1;
                        pass            <= 1'b0;
                        err_code        <= ERR_OK;
                        id_value        <= '0;
                        timestamp_value <= '0;
                        avm_read        <= 1'b1;
                        avm_address     <= 1'b0;
                        wait_timer      <= '0;
                    end
                end

                ID_CMD, TS_CMD: begin
                    wait_timer <= wait_timer + 16'd1;
                    if (timed_out) begin
                        err_code    <= ERR_TIMEOUT;
                        avm_read    <= 1'b0;
                        avm_address <= 1'b0;
                        state       <= FINISH;
                    end else if (!avm_waitrequest) begin
                        avm_read    <= 1'b0;
                        avm_address <= 1'b0;
                        if (state == ID_CMD) begin
                            state <= ID_WAIT;
                        end else begin
                            state <= TS_WAIT;
                        end
                    end
                end

                ID_WAIT: begin
                    wait_timer <= wait_timer + 16'd1;
                    if (avm_readdatavalid) begin
                        id_value <= avm_readdata;
                        if (avm_readdata != EXPECTED_ID) begin
                            err_code <= ERR_ID;
                            state    <= FINISH;
                        end else if (CHECK_TIMESTAMP != 0) begin
                            state       <= TS_CMD;
                            avm_read    <= 1'b1;
                            avm_address <= 1'b1;
                            wait_timer  <= '0;
                        end else begin
                            state <= FINISH;
                        end
                    end else if (timed_out) begin
                        err_code <= ERR_TIMEOUT;
                        state    <= FINISH;
                    end
                end

                TS_WAIT: begin
                    wait_timer <= wait_timer + 16'd1;
                    if (avm_readdatavalid) begin
                        timestamp_value <= avm_readdata;
                        if (avm_readdata != EXPECTED_TIMESTAMP) begin
                            err_code <= ERR_TS;
                        end
                        state <= FINISH;
                    end else if (timed_out) begin
                        err_code <= ERR_TIMEOUT;
                        state    <= FINISH;
                    end
                end

                FINISH: begin
                    done  <= 1'b1;
                    pass  <= (err_code == ERR_OK);
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deca_qsys_sysid_checker.sv
// Directed bench: DUT 0 uses default parameters, DUT 1 uses TIMEOUT_CYCLES=8 and
// CHECK_TIMESTAMP=0; a behavioural sysid slave answers each from the bench.
module tb_deca_qsys_sysid_checker;

    localparam logic [31:0] TS_GOOD = 32'd1429701634;

    logic        clock;
    logic        reset_n;
    logic        start             [2];
    logic        busy              [2];
    logic        done              [2];
    logic        pass              [2];
    logic [1:0]  err_code          [2];
    logic [31:0] id_value          [2];
    logic [31:0] timestamp_value   [2];
    logic        avm_address       [2];
    logic        avm_read          [2];
    logic        avm_waitrequest   [2];
    logic [31:0] avm_readdata      [2];
    logic        avm_readdatavalid [2];

    int          wait_cycles [2];
    logic [31:0] slave_data0 [2];
    logic [31:0] slave_data1 [2];
    bit          respond     [2];
    bit          force_rdv   [2];
    int          reads       [2];
    int          stab_err    [2];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          dut;
        int          wait_cycles;
        logic [31:0] data0;
        logic [31:0] data1;
        bit          respond;
        bit          exp_pass;
        logic [1:0]  exp_err;
        logic [31:0] exp_id;
        logic [31:0] exp_ts;
        int          exp_reads;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    deca_qsys_sysid_checker dut_a (
        .clock(clock), .reset_n(reset_n), .start(start[0]), .busy(busy[0]),
        .done(done[0]), .pass(pass[0]), .err_code(err_code[0]),
        .id_value(id_value[0]), .timestamp_value(timestamp_value[0]),
        .avm_address(avm_address[0]), .avm_read(avm_read[0]),
        .avm_waitrequest(avm_waitrequest[0]), .avm_readdata(avm_readdata[0]),
        .avm_readdatavalid(avm_readdatavalid[0])
    );

    deca_qsys_sysid_checker #(
        .CHECK_TIMESTAMP(0),
        .TIMEOUT_CYCLES(8)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start[1]), .busy(busy[1]),
        .done(done[1]), .pass(pass[1]), .err_code(err_code[1]),
        .id_value(id_value[1]), .timestamp_value(timestamp_value[1]),
        .avm_address(avm_address[1]), .avm_read(avm_read[1]),
        .avm_waitrequest(avm_waitrequest[1]), .avm_readdata(avm_readdata[1]),
        .avm_readdatavalid(avm_readdatavalid[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Slave model: stalls wait_cycles per command, then answers one cycle after acceptance.
    initial begin
        int   stall_cnt [2];
        bit   pending   [2];
        logic pend_addr [2];
        bit   prev_stall[2];
        logic prev_addr [2];
        for (int i = 0; i < 2; i++) begin
            avm_waitrequest[i] = 1'b0;
            avm_readdatavalid[i] = 1'b0;
            avm_readdata[i] = '0;
            stall_cnt[i] = 0;
            pending[i] = 1'b0;
            pend_addr[i] = 1'b0;
            prev_stall[i] = 1'b0;
            prev_addr[i] = 1'b0;
        end
        forever begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                if (prev_stall[i] && (avm_read[i] !== 1'b1 || avm_address[i] !== prev_addr[i]))
                    stab_err[i]++;
                prev_stall[i] = 1'b0;
                avm_readdatavalid[i] = 1'b0;
                if (pending[i]) begin
                    avm_readdatavalid[i] = 1'b1;
                    avm_readdata[i] = pend_addr[i] ? slave_data1[i] : slave_data0[i];
                    pending[i] = 1'b0;
                end else if (force_rdv[i]) begin
                    avm_readdatavalid[i] = 1'b1;
                    avm_readdata[i] = 32'h0000_0055;
                    force_rdv[i] = 1'b0;
                end
                if (avm_read[i] === 1'b1 && reset_n) begin
                    if (stall_cnt[i] < wait_cycles[i]) begin
                        avm_waitrequest[i] = 1'b1;
                        stall_cnt[i]++;
                        prev_stall[i] = 1'b1;
                        prev_addr[i] = avm_address[i];
                    end else begin
                        avm_waitrequest[i] = 1'b0;
                        stall_cnt[i] = 0;
                        reads[i]++;
                        pending[i] = respond[i];
                        pend_addr[i] = avm_address[i];
                    end
                end else begin
                    avm_waitrequest[i] = 1'b0;
                    stall_cnt[i] = 0;
                end
            end
        end
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pulses start, optionally re-pulses it while busy, and measures start-to-done cycles.
    task automatic apply_stimulus(input vec_t v, input bit extra_starts, output int lat);
        int d;
        d = v.dut;
        wait_cycles[d] = v.wait_cycles;
        slave_data0[d] = v.data0;
        slave_data1[d] = v.data1;
        respond[d] = v.respond;
        @(negedge clock);
        reads[d] = 0;
        stab_err[d] = 0;
        start[d] = 1'b1;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            start[d] = extra_starts && (lat == 2 || lat == 4);
        end while (done[d] !== 1'b1 && lat < 200);
        start[d] = 1'b0;
        if (lat >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_wait: got no done in %0d cycles, expected done", lat);
        end
    endtask

    task automatic check_output(input vec_t v, input int idx, input int lat);
        int d;
        d = v.dut;
        check_val($sformatf("v%0d_pass", idx), 32'(pass[d]), 32'(v.exp_pass));
        check_val($sformatf("v%0d_err", idx), 32'(err_code[d]), 32'(v.exp_err));
        check_val($sformatf("v%0d_id", idx), id_value[d], v.exp_id);
        check_val($sformatf("v%0d_ts", idx), timestamp_value[d], v.exp_ts);
        check_val($sformatf("v%0d_reads", idx), 32'(reads[d]), 32'(v.exp_reads));
        check_val($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
        check_val($sformatf("v%0d_stable", idx), 32'(stab_err[d]), 32'd0);
    endtask

    initial begin
        int   lat;
        vec_t good;
        //         dut wait data0         data1         rsp pass err   id            ts            rd lat
        vecs[0] = '{0, 0, 32'd0,         TS_GOOD,      1, 1, 2'd0, 32'd0,        TS_GOOD,      2, 6};
        vecs[1] = '{0, 0, 32'h0000_0001, TS_GOOD,      1, 0, 2'd1, 32'h1,        32'd0,        1, 4};
        vecs[2] = '{0, 5, 32'd0,         TS_GOOD,      1, 1, 2'd0, 32'd0,        TS_GOOD,      2, 16};
        vecs[3] = '{0, 0, 32'd0,         32'h0000_1234,1, 0, 2'd2, 32'd0,        32'h1234,     2, 6};
        vecs[4] = '{0, 0, 32'hFFFF_FFFF, TS_GOOD,      1, 0, 2'd1, 32'hFFFF_FFFF,32'd0,        1, 4};
        vecs[5] = '{1, 0, 32'd0,         32'hDEAD_BEEF,1, 1, 2'd0, 32'd0,        32'd0,        1, 4};
        vecs[6] = '{1, 0, 32'd0,         TS_GOOD,      0, 0, 2'd3, 32'd0,        32'd0,        1, 10};
        good = vecs[0];

        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            wait_cycles[i] = 0;
            slave_data0[i] = '0;
            slave_data1[i] = '0;
            respond[i] = 1'b1;
            force_rdv[i] = 1'b0;
            reads[i] = 0;
            stab_err[i] = 0;
        end
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check_val("rst_busy", 32'(busy[0]), 32'd0);
        check_val("rst_done", 32'(done[0]), 32'd0);
        check_val("rst_pass", 32'(pass[0]), 32'd0);
        check_val("rst_err", 32'(err_code[0]), 32'd0);
        check_val("rst_id_ts", id_value[0] | timestamp_value[0], 32'd0);
        check_val("rst_avm", 32'({avm_read[0], avm_address[0]}), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i], 1'b0, lat);
            check_output(vecs[i], i, lat);
        end

        // Late response after the timeout must not be captured.
        force_rdv[1] = 1'b1;
        repeat (3) @(negedge clock);
        check_val("late_id", id_value[1], 32'd0);
        check_val("late_err", 32'(err_code[1]), 32'd3);
        check_val("late_done", 32'(done[1]), 32'd0);
        check_val("late_busy", 32'(busy[1]), 32'd0);

        // Reset in the middle of ID_WAIT, then a clean check.
        respond[0] = 1'b0;
        wait_cycles[0] = 0;
        @(negedge clock);
        start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        @(negedge clock);
        check_val("midrst_busy_before", 32'(busy[0]), 32'd1);
        reset_n = 1'b0;
        #1;
        check_val("midrst_busy", 32'(busy[0]), 32'd0);
        check_val("midrst_avm_read", 32'(avm_read[0]), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        apply_stimulus(good, 1'b0, lat);
        check_output(good, 10, lat);

        // Start pulses while busy, then a start coinciding with done.
        apply_stimulus(good, 1'b1, lat);
        check_output(good, 11, lat);
        start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        check_val("done_start_busy", 32'(busy[0]), 32'd0);
        check_val("done_start_read", 32'(avm_read[0]), 32'd0);
        check_val("done_start_pass", 32'(pass[0]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/deca_qsys_sysid_checker.md
Name: deca_qsys_sysid_checker

Overview:
- Avalon-MM master that reads the Qsys system-ID slave: ID word at address 0, timestamp word at address 1.
- Compares both words against build-time expected values and reports pass/fail plus the captured values.
- Sits beside the Nios/DDR3 test logic so a board-level self-test can confirm the loaded FPGA image matches the software build, without the CPU.
- Only one read is outstanding at a time; each read has a timeout.

Parameters:
- EXPECTED_ID, 32'd0, expected value at slave address 0.
- EXPECTED_TIMESTAMP, 32'd1429701634, expected value at slave address 1.
- CHECK_TIMESTAMP, 1, 1 = read and compare address 1; 0 = skip the timestamp phase.
- TIMEOUT_CYCLES, 255, maximum cycles allowed from asserting avm_read to readdatavalid. Range 1..65535.

Ports:
- clock  input  1  single system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a check; ignored while busy.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the check completes.
- pass  output  1  result of the last check; valid from done until the next start.
- err_code  output  2  0 = ok, 1 = ID mismatch, 2 = timestamp mismatch, 3 = timeout.
- id_value  output  32  captured address-0 word.
- timestamp_value  output  32  captured address-1 word.
- avm_address  output  1  word address to the sysid slave.
- avm_read  output  1  read request.
- avm_waitrequest  input  1  slave stall.
- avm_readdata  input  32  read data.
- avm_readdatavalid  input  1  read data qualifier; arbitrary latency ≥1 cycle after the command is accepted.

Behaviour:
- Reset values: all outputs 0; state = IDLE; timeout counter = 0.
- FSM states: IDLE, ID_CMD, ID_WAIT, TS_CMD, TS_WAIT, FINISH.
- IDLE:
  - start=1 → ID_CMD.
  - Same edge: busy←1, pass←0, err_code←0, id_value←0, timestamp_value←0.
- ID_CMD:
  - avm_read=1, avm_address=0; held stable while avm_waitrequest=1.
  - Command accepted on the edge where avm_waitrequest=0 → ID_WAIT, avm_read←0.
- ID_WAIT:
  - On avm_readdatavalid: id_value←avm_readdata.
  - If the data ≠ EXPECTED_ID: err_code←1 → FINISH.
  - Else if CHECK_TIMESTAMP=1 → TS_CMD.
  - Else → FINISH with pass.
- TS_CMD / TS_WAIT: same as ID_CMD / ID_WAIT with avm_address=1 and timestamp_value captured; a mismatch sets err_code←2.
- Timeout counter:
  - Cleared on entry to each *_CMD state; increments every cycle in *_CMD and *_WAIT.
  - When it reaches TIMEOUT_CYCLES with no readdatavalid: err_code←3, avm_read←0 → FINISH.
  - readdatavalid in the same cycle the count reaches TIMEOUT_CYCLES is a valid response; data wins, no timeout.
- FINISH (one cycle): done=1; pass = (err_code==0); busy←0 → IDLE.
- Result retention: pass, err_code, id_value and timestamp_value hold until the next accepted start.
- readdatavalid outside *_WAIT (e.g. a late response after a timeout) is ignored; nothing is captured.
- start while busy: ignored, no queueing. A start in the same cycle as done is also ignored; it is accepted only in IDLE.
- Asynchronous reset mid-transaction: the FSM returns to IDLE and avm_read drops immediately. The slave is assumed to tolerate an abandoned read.
- avm_address is driven 0 outside the CMD states.
- Latency with waitrequest=0 and 1-cycle readdatavalid: start to done = 6 cycles with CHECK_TIMESTAMP=1, 4 cycles with CHECK_TIMESTAMP=0.

Test Plan:
- Slave with zero-wait, 1-cycle latency returns 0 at address 0 and 1429701634 at address 1; pulse start → two reads at addresses 0 then 1, done after 6 cycles, pass=1, err_code=0, id_value=0, timestamp_value=1429701634.
- Slave returns 32'h0000_0001 at address 0 → only one read issued, done with pass=0, err_code=1, id_value=1, timestamp_value=0.
- avm_waitrequest held high 5 cycles on each command → avm_read and avm_address stay stable throughout, pass=1, start-to-done = 16 cycles.
- TIMEOUT_CYCLES=8 and the slave never asserts readdatavalid → done 8 cycles after the first read cycle, err_code=3, pass=0. A late readdatavalid afterwards changes nothing.
- Assert reset_n low mid ID_WAIT, release, then pulse start → all outputs 0 during reset, and a clean check completes with pass=1. A start pulse while busy has no effect on the read sequence.
- CHECK_TIMESTAMP=0, timestamp slave value wrong → only the address-0 read is issued, pass=1, timestamp_value=0.
